// File: rtl/ps2_kbd_sequencer.sv
// ps2_kbd_sequencer: PS/2 keyboard power-up sequencer and tx arbiter.
// Waits for BAT (0xAA), sends the init ROM with ACK/resend, then runs.
// Ports:
//   clk, reset          clock, sync active-high reset
//   ps2_tx_*            byte request to ps2_host (valid/ready)
//   ps2_rx_*            byte from ps2_host (user = parity error)
//   cmd_*               runtime command in, done/fail pulses out
//   sc_*                scancode stream to the consumer
//   init_done/fail      init status levels
//   err_count           saturating FE/timeout/parity event count
// Option: PS2_SEQ_PARITY_RESEND_EN answers a RUN parity error with 0xFE.
module ps2_kbd_sequencer #(
  parameter int CLK_PER        = 10,
  parameter int ACK_TIMEOUT_US = 20000,
  parameter int BAT_TIMEOUT_US = 1000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       reset,
  output logic       ps2_tx_valid,
  output logic [7:0] ps2_tx_data,
  input  logic       ps2_tx_ready,
  input  logic       ps2_rx_valid,
  input  logic [7:0] ps2_rx_data,
  input  logic       ps2_rx_user,
  output logic       ps2_rx_ready,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_op,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  output logic       cmd_ready,
  output logic       cmd_done,
  output logic       cmd_fail,
  output logic       sc_valid,
  output logic [7:0] sc_data,
  output logic       sc_err,
  input  logic       sc_ready,
  output logic       init_done,
  output logic       init_fail,
  output logic [7:0] err_count
);

  localparam int ACK_CYC = ACK_TIMEOUT_US * 1000 / CLK_PER;
  localparam int BAT_CYC = BAT_TIMEOUT_US * 1000 / CLK_PER;
  localparam logic [31:0] ACK_LAST = 32'(ACK_CYC - 1);
  localparam logic [31:0] BAT_LAST = 32'(BAT_CYC - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_BAT_WAIT,
    S_BAT_RST,
    S_BAT_ACK,
    S_SEQ_SEND,
    S_ACK_WAIT,
    S_RUN,
    S_CMD_OP,
    S_CMD_ACK,
    S_CMD_ARG,
    S_CMD_ARG_ACK,
    S_PAR_SEND,
    S_FAIL
  } state_t;

  state_t      r_state;
  state_t      w_nxt;
  logic [31:0] r_tmr;
  logic [2:0]  r_ptr;
  logic [7:0]  r_retry;
  logic [7:0]  r_op;
  logic [7:0]  r_arg;
  logic        r_has_arg;
  logic [7:0]  r_err;
  logic        r_init_done;
  logic        r_init_fail;
  logic        r_cmd_done;
  logic        r_cmd_fail;

  logic w_ack_st;
  logic w_send;
  logic w_rsp;
  logic w_ok;
  logic w_bad;
  logic w_tmo;
  logic w_err;
  logic w_last;
  logic w_hs;
  logic w_acc;
  logic w_aa;
  logic w_par;

  function automatic logic [7:0] rom(input logic [2:0] p);
    unique case (p)
      3'd0:    rom = 8'hED;
      3'd1:    rom = 8'h00;
      3'd2:    rom = 8'hF3;
      3'd3:    rom = 8'h20;
      default: rom = 8'hF4;
    endcase
  endfunction

  assign w_ack_st = (r_state == S_BAT_ACK)
                  | (r_state == S_ACK_WAIT)
                  | (r_state == S_CMD_ACK)
                  | (r_state == S_CMD_ARG_ACK);
  assign w_send = (r_state == S_BAT_RST)
                | (r_state == S_SEQ_SEND)
                | (r_state == S_CMD_OP)
                | (r_state == S_CMD_ARG)
                | (r_state == S_PAR_SEND);

  // Bytes the sequencer itself consumes while waiting for an ACK.
  assign w_rsp = ps2_rx_user
               | (ps2_rx_data == 8'hFA)
               | (ps2_rx_data == 8'hFE);
  assign w_ok = w_ack_st & ps2_rx_valid & ~ps2_rx_user
              & (ps2_rx_data == 8'hFA);
  assign w_bad = w_ack_st & ps2_rx_valid
               & (ps2_rx_user | (ps2_rx_data == 8'hFE));
  // A response on the timeout cycle wins over the timeout.
  assign w_tmo = w_ack_st & ~w_ok & ~w_bad & (r_tmr == ACK_LAST);
  assign w_err = w_bad | w_tmo;
  assign w_last = (r_retry == RETRY_MAX);
  assign w_hs = w_send & ps2_tx_ready;
  assign w_acc = cmd_valid & cmd_ready;
  assign w_aa = (r_state == S_BAT_WAIT) & ps2_rx_valid
              & ~ps2_rx_user & (ps2_rx_data == 8'hAA);

`ifdef PS2_SEQ_PARITY_RESEND_EN
  assign w_par = (r_state == S_RUN) & ps2_rx_valid & ps2_rx_user;
`else
  assign w_par = 1'b0;
`endif

  assign ps2_tx_valid = w_send;
  assign cmd_done     = r_cmd_done;
  assign cmd_fail     = r_cmd_fail;
  assign init_done    = r_init_done;
  assign init_fail    = r_init_fail;
  assign err_count    = r_err;

  always_comb begin
    ps2_tx_data = 8'h00;
    case (r_state)
      S_BAT_RST:  ps2_tx_data = 8'hFF;
      S_SEQ_SEND: ps2_tx_data = rom(r_ptr);
      S_CMD_OP:   ps2_tx_data = r_op;
      S_CMD_ARG:  ps2_tx_data = r_arg;
      S_PAR_SEND: ps2_tx_data = 8'hFE;
      default:    ps2_tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_BAT_WAIT;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt        = r_state;
    ps2_rx_ready = 1'b0;
    sc_valid     = 1'b0;
    sc_data      = 8'h00;
    sc_err       = 1'b0;
    cmd_ready    = 1'b0;
    if (w_ack_st) begin
      if (w_rsp) begin
        ps2_rx_ready = ps2_rx_valid;
      end else begin
        sc_valid     = ps2_rx_valid;
        sc_data      = ps2_rx_data;
        ps2_rx_ready = sc_ready;
      end
    end
    unique case (r_state)
      S_BAT_WAIT: begin
        ps2_rx_ready = ps2_rx_valid;
        if (w_aa)                  w_nxt = S_SEQ_SEND;
        else if (r_tmr == BAT_LAST) w_nxt = S_BAT_RST;
      end
      S_BAT_RST:
        if (w_hs) w_nxt = S_BAT_ACK;
      S_BAT_ACK:
        if (w_ok)       w_nxt = S_BAT_WAIT;
        else if (w_err) w_nxt = w_last ? S_FAIL : S_BAT_RST;
      S_SEQ_SEND:
        if (w_hs) w_nxt = S_ACK_WAIT;
      S_ACK_WAIT:
        if (w_ok)
          w_nxt = (r_ptr == 3'd4) ? S_RUN : S_SEQ_SEND;
        else if (w_err)
          w_nxt = w_last ? S_FAIL : S_SEQ_SEND;
      S_RUN: begin
        if (w_par) begin
          ps2_rx_ready = 1'b1;
          w_nxt        = S_PAR_SEND;
        end else begin
          sc_valid     = ps2_rx_valid;
          sc_data      = ps2_rx_data;
          sc_err       = ps2_rx_user;
          ps2_rx_ready = sc_ready;
          cmd_ready    = 1'b1;
          if (cmd_valid) w_nxt = S_CMD_OP;
        end
      end
      S_CMD_OP:
        if (w_hs) w_nxt = S_CMD_ACK;
      S_CMD_ACK:
        if (w_ok)
          w_nxt = r_has_arg ? S_CMD_ARG : S_RUN;
        else if (w_err)
          w_nxt = w_last ? S_RUN : S_CMD_OP;
      S_CMD_ARG:
        if (w_hs) w_nxt = S_CMD_ARG_ACK;
      S_CMD_ARG_ACK:
        if (w_ok)       w_nxt = S_RUN;
        else if (w_err) w_nxt = w_last ? S_RUN : S_CMD_ARG;
      S_PAR_SEND:
        if (w_hs) w_nxt = S_RUN;
      S_FAIL:
        ps2_rx_ready = ps2_rx_valid;
      default:
        w_nxt = S_BAT_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmr       <= '0;
      r_ptr       <= '0;
      r_retry     <= '0;
      r_op        <= '0;
      r_arg       <= '0;
      r_has_arg   <= 1'b0;
      r_err       <= '0;
      r_init_done <= 1'b0;
      r_init_fail <= 1'b0;
      r_cmd_done  <= 1'b0;
      r_cmd_fail  <= 1'b0;
    end else begin
      r_cmd_done <= 1'b0;
      r_cmd_fail <= 1'b0;
      // Timer restarts on every handshake and state change.
      if (w_hs || (w_nxt != r_state)) r_tmr <= '0;
      else                            r_tmr <= r_tmr + 32'd1;
      if (w_aa)
        r_ptr <= '0;
      else if (w_ok && (r_state == S_ACK_WAIT) && (r_ptr != 3'd4))
        r_ptr <= r_ptr + 3'd1;
      if (w_ok || w_aa || w_acc || (w_err && w_last))
        r_retry <= '0;
      else if (w_err)
        r_retry <= r_retry + 8'd1;
      // Only errors that lead to a resend are counted.
      if (((w_err && !w_last) || w_par) && (r_err != 8'hFF))
        r_err <= r_err + 8'd1;
      if (w_acc) begin
        r_op      <= cmd_op;
        r_arg     <= cmd_arg;
        r_has_arg <= cmd_has_arg;
      end
      if (w_ok && (r_state == S_ACK_WAIT) && (r_ptr == 3'd4))
        r_init_done <= 1'b1;
      if ((w_nxt == S_FAIL) && (r_state != S_FAIL))
        r_init_fail <= 1'b1;
      if (w_ok && (((r_state == S_CMD_ACK) && !r_has_arg)
                   || (r_state == S_CMD_ARG_ACK)))
        r_cmd_done <= 1'b1;
      if (w_err && w_last
          && ((r_state == S_CMD_ACK) || (r_state == S_CMD_ARG_ACK)))
        r_cmd_fail <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_sequencer.sv
// tb_ps2_kbd_sequencer: directed bench for ps2_kbd_sequencer.
// RUN routing table plus init / resend / fail / BAT / command sequences.
module tb_ps2_kbd_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_tx_valid;
  logic [7:0] ps2_tx_data;
  logic       ps2_tx_ready = 1'b0;
  logic       ps2_rx_valid = 1'b0;
  logic [7:0] ps2_rx_data = 8'h00;
  logic       ps2_rx_user = 1'b0;
  logic       ps2_rx_ready;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_op = 8'h00;
  logic       cmd_has_arg = 1'b0;
  logic [7:0] cmd_arg = 8'h00;
  logic       cmd_ready;
  logic       cmd_done;
  logic       cmd_fail;
  logic       sc_valid;
  logic [7:0] sc_data;
  logic       sc_err;
  logic       sc_ready = 1'b1;
  logic       init_done;
  logic       init_fail;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int fail_cnt = 0;
  int early_rdy = 0;

  typedef struct {
    logic       rv;
    logic [7:0] rd;
    logic       ru;
    logic       sr;
    logic       e_scv;
    logic [7:0] e_scd;
    logic       e_sce;
    logic       e_rr;
    logic       e_cr;
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  ps2_kbd_sequencer #(
    .CLK_PER       (10),
    .ACK_TIMEOUT_US(2),
    .BAT_TIMEOUT_US(5),
    .MAX_RETRY     (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_tx_valid(ps2_tx_valid),
    .ps2_tx_data (ps2_tx_data),
    .ps2_tx_ready(ps2_tx_ready),
    .ps2_rx_valid(ps2_rx_valid),
    .ps2_rx_data (ps2_rx_data),
    .ps2_rx_user (ps2_rx_user),
    .ps2_rx_ready(ps2_rx_ready),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_has_arg (cmd_has_arg),
    .cmd_arg     (cmd_arg),
    .cmd_ready   (cmd_ready),
    .cmd_done    (cmd_done),
    .cmd_fail    (cmd_fail),
    .sc_valid    (sc_valid),
    .sc_data     (sc_data),
    .sc_err      (sc_err),
    .sc_ready    (sc_ready),
    .init_done   (init_done),
    .init_fail   (init_fail),
    .err_count   (err_count)
  );

  always @(negedge clk) begin
    if (cmd_done === 1'b1) done_cnt++;
    if (cmd_fail === 1'b1) fail_cnt++;
    if (cmd_ready === 1'b1 && init_done !== 1'b1) early_rdy++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ps2_rx_valid = 1'b0;
    ps2_rx_user = 1'b0;
    ps2_tx_ready = 1'b0;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_reset(input string t);
    chk({t, " tx_valid"}, ps2_tx_valid, 0);
    chk({t, " tx_data"}, ps2_tx_data, 0);
    chk({t, " rx_ready"}, ps2_rx_ready, 0);
    chk({t, " cmd_ready"}, cmd_ready, 0);
    chk({t, " cmd_done"}, cmd_done, 0);
    chk({t, " cmd_fail"}, cmd_fail, 0);
    chk({t, " sc_valid"}, sc_valid, 0);
    chk({t, " sc_data"}, sc_data, 0);
    chk({t, " sc_err"}, sc_err, 0);
    chk({t, " init_done"}, init_done, 0);
    chk({t, " init_fail"}, init_fail, 0);
    chk({t, " err_count"}, err_count, 0);
  endtask

  // Waits for a tx request, checks the byte, then completes the handshake.
  task automatic wait_tx(input string name, input logic [7:0] exp,
                         output int gap);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 2000) begin
      @(negedge clk);
      n++;
      if (ps2_tx_valid === 1'b1) seen = 1'b1;
    end
    gap = n;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: no tx seen, expected %0h", name, exp);
    end else begin
      chk(name, ps2_tx_data, exp);
      ps2_tx_ready = 1'b1;
      @(posedge clk);
      #1;
      ps2_tx_ready = 1'b0;
    end
  endtask

  task automatic send_rx(input string name, input logic [7:0] d,
                         input logic u);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    ps2_rx_valid = 1'b1;
    ps2_rx_data = d;
    ps2_rx_user = u;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (ps2_rx_ready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    ps2_rx_valid = 1'b0;
    ps2_rx_user = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: rx byte %0h not accepted", name, d);
    end
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic ha,
                          input logic [7:0] arg, input string name);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_has_arg = ha;
    cmd_arg = arg;
    #1;
    chk({name, " cmd_ready"}, cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk({name, " busy"}, cmd_ready, 0);
  endtask

  task automatic init_rom(input string t);
    int g;
    wait_tx({t, " ED"}, 8'hED, g);
    send_rx({t, " ack0"}, 8'hFA, 1'b0);
    wait_tx({t, " 00"}, 8'h00, g);
    send_rx({t, " ack1"}, 8'hFA, 1'b0);
    wait_tx({t, " F3"}, 8'hF3, g);
    send_rx({t, " ack2"}, 8'hFA, 1'b0);
    wait_tx({t, " 20"}, 8'h20, g);
    send_rx({t, " ack3"}, 8'hFA, 1'b0);
    wait_tx({t, " F4"}, 8'hF4, g);
    send_rx({t, " ack4"}, 8'hFA, 1'b0);
  endtask

  initial begin
    int gap;
    int n;
    tbl[0] = '{1, 8'h1C, 0, 1, 1, 8'h1C, 0, 1, 1};
    tbl[1] = '{1, 8'h1C, 0, 0, 1, 8'h1C, 0, 0, 1};
    tbl[2] = '{0, 8'h55, 0, 1, 0, 8'h55, 0, 1, 1};
    tbl[3] = '{1, 8'hFA, 0, 1, 1, 8'hFA, 0, 1, 1};
    tbl[4] = '{1, 8'hFE, 0, 0, 1, 8'hFE, 0, 0, 1};
`ifdef PS2_SEQ_PARITY_RESEND_EN
    tbl[5] = '{1, 8'h1C, 1, 1, 0, 8'h00, 0, 1, 0};
`else
    tbl[5] = '{1, 8'h1C, 1, 1, 1, 8'h1C, 1, 1, 1};
`endif
    tbl[6] = '{1, 8'hF0, 0, 1, 1, 8'hF0, 0, 1, 1};

    // Clean init.
    do_reset();
    chk_reset("rst");
    send_rx("bat aa", 8'hAA, 1'b0);
    init_rom("clean");
    chk("clean init_done", init_done, 1);
    chk("clean init_fail", init_fail, 0);
    chk("clean err_count", err_count, 0);

    // RUN-state routing table, combinational only.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ps2_rx_valid = tbl[i].rv;
      ps2_rx_data = tbl[i].rd;
      ps2_rx_user = tbl[i].ru;
      sc_ready = tbl[i].sr;
      #1;
      chk($sformatf("vec%0d sc_valid", i), sc_valid, tbl[i].e_scv);
      chk($sformatf("vec%0d sc_data", i), sc_data, tbl[i].e_scd);
      chk($sformatf("vec%0d sc_err", i), sc_err, tbl[i].e_sce);
      chk($sformatf("vec%0d rx_ready", i), ps2_rx_ready, tbl[i].e_rr);
      chk($sformatf("vec%0d cmd_ready", i), cmd_ready, tbl[i].e_cr);
      #1;
      ps2_rx_valid = 1'b0;
      ps2_rx_user = 1'b0;
      sc_ready = 1'b1;
    end
    chk("table err_count", err_count, 0);

    // LED command with a scancode arriving before the ACK.
    done_cnt = 0;
    send_cmd(8'hED, 1'b1, 8'h07, "led");
    wait_tx("led op", 8'hED, gap);
    @(negedge clk);
    ps2_rx_valid = 1'b1;
    ps2_rx_data = 8'h1C;
    #1;
    chk("led sc_valid", sc_valid, 1);
    chk("led sc_data", sc_data, 8'h1C);
    chk("led rx_ready", ps2_rx_ready, 1);
    @(posedge clk);
    #1;
    ps2_rx_valid = 1'b0;
    send_rx("led ack op", 8'hFA, 1'b0);
    wait_tx("led arg", 8'h07, gap);
    send_rx("led ack arg", 8'hFA, 1'b0);
    repeat (4) @(negedge clk);
    chk("led cmd_done pulses", done_cnt, 1);
    chk("led err_count", err_count, 0);

    // Command with no ACK at all: abandoned after the retries.
    done_cnt = 0;
    fail_cnt = 0;
    send_cmd(8'hEE, 1'b0, 8'h00, "nack");
    for (int k = 0; k < 4; k++) begin
      wait_tx($sformatf("nack tx%0d", k), 8'hEE, gap);
      if (k > 0)
        chk($sformatf("nack gap%0d", k),
            (gap >= 195 && gap <= 205), 1);
    end
    repeat (220) @(negedge clk);
    chk("nack cmd_fail pulses", fail_cnt, 1);
    chk("nack cmd_done pulses", done_cnt, 0);
    chk("nack err_count", err_count, 3);
    chk("nack back in run", cmd_ready, 1);

`ifdef PS2_SEQ_PARITY_RESEND_EN
    send_rx("par rx", 8'h1C, 1'b1);
    wait_tx("par resend", 8'hFE, gap);
    chk("par err_count", err_count, 4);
`endif

    // FE on F3 forces an immediate resend.
    do_reset();
    send_rx("rs aa", 8'hAA, 1'b0);
    wait_tx("rs ED", 8'hED, gap);
    send_rx("rs ack0", 8'hFA, 1'b0);
    wait_tx("rs 00", 8'h00, gap);
    send_rx("rs ack1", 8'hFA, 1'b0);
    wait_tx("rs F3", 8'hF3, gap);
    send_rx("rs fe", 8'hFE, 1'b0);
    chk("rs retx valid", ps2_tx_valid, 1);
    chk("rs retx data", ps2_tx_data, 8'hF3);
    wait_tx("rs F3 again", 8'hF3, gap);
    send_rx("rs ack2", 8'hFA, 1'b0);
    wait_tx("rs 20", 8'h20, gap);
    send_rx("rs ack3", 8'hFA, 1'b0);
    wait_tx("rs F4", 8'hF4, gap);
    send_rx("rs ack4", 8'hFA, 1'b0);
    chk("rs init_done", init_done, 1);
    chk("rs err_count", err_count, 1);

    // Silent keyboard after ED: four sends then terminal failure.
    do_reset();
    send_rx("if aa", 8'hAA, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_tx($sformatf("if ED%0d", k), 8'hED, gap);
      if (k > 0)
        chk($sformatf("if gap%0d", k),
            (gap >= 195 && gap <= 205), 1);
    end
    repeat (220) @(negedge clk);
    chk("if init_fail", init_fail, 1);
    chk("if init_done", init_done, 0);
    chk("if err_count", err_count, 3);
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (ps2_tx_valid === 1'b1) n++;
    end
    chk("if no more tx", n, 0);
    send_rx("if late aa", 8'hAA, 1'b0);
    chk("if stays failed", init_fail, 1);
    do_reset();
    chk_reset("rst2");

    // No BAT: keyboard reset, then init; a command waits for RUN.
    do_reset();
    cmd_valid = 1'b1;
    cmd_op = 8'hF4;
    cmd_has_arg = 1'b0;
    early_rdy = 0;
    wait_tx("nb FF", 8'hFF, gap);
    chk("nb bat gap", (gap >= 495 && gap <= 505), 1);
    send_rx("nb ack", 8'hFA, 1'b0);
    send_rx("nb aa", 8'hAA, 1'b0);
    init_rom("nb");
    chk("nb init_done", init_done, 1);
    chk("nb held cmd ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("nb cmd held off", early_rdy, 0);
    done_cnt = 0;
    wait_tx("nb cmd F4", 8'hF4, gap);
    send_rx("nb cmd ack", 8'hFA, 1'b0);
    repeat (3) @(negedge clk);
    chk("nb cmd_done pulses", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
